seg7_scanner: RTL and testbench

- Downstream display stage for the Nexys 3 top wrapper.
- Consumes the CPU's 32-bit ALU result and its ZF/OF flags.
- Drives the board's 4-digit multiplexed seven-segment display as hex.
- Time-multiplexes the digits, inserts anti-ghosting blank gaps, and can freeze the shown value.

---
 rtl/seg7_scanner.sv | 178 +++++++++++++++++
 tb/tb_seg7_scanner.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scanner.sv
// -----------------------------------------------------------------------------
// seg7_scanner
//
// Display stage for the 4-digit multiplexed seven-segment display. It shows
// one 16-bit half of the ALU result as four hex digits. The ZF and OF flags and
// the selected half are shown on the decimal points. Digits are lit one at a
// time. An all-off blank gap between digits suppresses ghosting. A snapshot
// register lets the shown value be frozen.
//
// Ports
//   CLK    in   1   system clock, all state changes on the rising edge
//   RST    in   1   asynchronous active-low reset
//   value  in  32   ALU result to display
//   zf     in   1   ALU zero flag      (decimal point of digit 0)
//   of     in   1   ALU overflow flag  (decimal point of digit 1)
//   half   in   1   0 = show value[15:0], 1 = show value[31:16] (dp of digit 3)
//   hold   in   1   1 = freeze the snapshot of {value, zf, of, half}
//   AN     out  4   digit anodes, active-low, AN[0] = rightmost digit
//   SEG    out  8   segment cathodes, active-low, SEG[6:0] = g..a, SEG[7] = dp
//
// Parameters
//   REFRESH_DIV   clock cycles each digit stays lit (>= 1)
//   BLANK_CYCLES  clock cycles with all anodes off between digits (0 = no gap)
// -----------------------------------------------------------------------------
module seg7_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] value,
  input  logic        zf,
  input  logic        of,
  input  logic        half,
  input  logic        hold,
  output logic [3:0]  AN,
  output logic [7:0]  SEG
);

  // Counter widths: $clog2 of the parameter, never narrower than one bit.
  localparam int PW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW      = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int BLK_MAX = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLK_LAST = BW'(BLK_MAX);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    digit_q, digit_d;
  logic [PW-1:0] pre_q,   pre_d;
  logic [BW-1:0] blk_q,   blk_d;

  logic [31:0]   snap_value_q;
  logic          snap_zf_q, snap_of_q, snap_half_q;

  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic [15:0]   half_word;
  logic [3:0]    nibble;
  logic          dp;

  // Active-low hex glyphs, bit 0 = segment a.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    case (n)
      4'h0: p = 7'h40;
      4'h1: p = 7'h79;
      4'h2: p = 7'h24;
      4'h3: p = 7'h30;
      4'h4: p = 7'h19;
      4'h5: p = 7'h12;
      4'h6: p = 7'h02;
      4'h7: p = 7'h78;
      4'h8: p = 7'h00;
      4'h9: p = 7'h10;
      4'hA: p = 7'h08;
      4'hB: p = 7'h03;
      4'hC: p = 7'h46;
      4'hD: p = 7'h21;
      4'hE: p = 7'h06;
      default: p = 7'h0E;
    endcase
    return p;
  endfunction

  // Snapshot: the display only ever renders from these registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      snap_value_q <= '0;
      snap_zf_q    <= 1'b0;
      snap_of_q    <= 1'b0;
      snap_half_q  <= 1'b0;
    end else if (!hold) begin
      snap_value_q <= value;
      snap_zf_q    <= zf;
      snap_of_q    <= of;
      snap_half_q  <= half;
    end
  end

  // Scan sequencer next state.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    pre_d   = pre_q;
    blk_d   = blk_q;
    case (state_q)
      ST_BLANK: begin
        if (blk_q == BLK_LAST) begin
          blk_d   = '0;
          pre_d   = '0;
          state_d = ST_SHOW;
        end else begin
          blk_d = blk_q + 1'b1;
        end
      end
      default: begin
        if (pre_q == PRE_LAST) begin
          pre_d   = '0;
          blk_d   = '0;
          digit_d = digit_q + 2'd1;
          // With no blank gap the next digit is shown straight away.
          state_d = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
        end else begin
          pre_d = pre_q + 1'b1;
        end
      end
    endcase
  end

  // Output decode. It is driven from the next state so that AN/SEG change on
  // the same edge as the state. The glyph comes from the registered snapshot,
  // so a snapshot change appears one edge after it has been loaded.
  always_comb begin
    half_word = snap_half_q ? snap_value_q[31:16] : snap_value_q[15:0];
    nibble    = half_word[{digit_d, 2'b00} +: 4];
    case (digit_d)
      2'd0:    dp = ~snap_zf_q;
      2'd1:    dp = ~snap_of_q;
      2'd2:    dp = 1'b1;
      default: dp = ~snap_half_q;
    endcase
    an_d  = 4'hF;
    seg_d = 8'hFF;
    if (state_d == ST_SHOW) begin
      an_d  = ~(4'b0001 << digit_d);
      seg_d = {dp, hex7(nibble)};
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_BLANK;
      digit_q <= 2'd0;
      pre_q   <= '0;
      blk_q   <= '0;
      an_q    <= 4'hF;
      seg_q   <= 8'hFF;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      pre_q   <= pre_d;
      blk_q   <= blk_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// -----------------------------------------------------------------------------
// Testbench for seg7_scanner with REFRESH_DIV=4 and BLANK_CYCLES=1.
// The reference model derives the display from the number of edges since
// reset release (the position within the scan period) and from a snapshot
// copy of the inputs.
// -----------------------------------------------------------------------------
module tb_seg7_scanner;

  localparam int RD = 4;
  localparam int BC = 1;
  localparam int P  = RD + BC;   // edges per digit slot (lit + blank)

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [31:0] value = '0;
  logic        zf = 1'b0, of = 1'b0, half = 1'b0, hold = 1'b0;
  logic [3:0]  AN;
  logic [7:0]  SEG;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: edges since reset release and the modelled snapshot.
  int          k = 0;
  logic [31:0] m_val = '0;
  logic        m_zf = 1'b0, m_of = 1'b0, m_half = 1'b0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [31:0] value;
    logic        zf;
    logic        of;
    logic        half;
    int          digit;
    logic [3:0]  an;
    logic [7:0]  seg;
  } vec_t;

  vec_t vecs [12];

  seg7_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .value (value),
    .zf    (zf),
    .of    (of),
    .half  (half),
    .hold  (hold),
    .AN    (AN),
    .SEG   (SEG)
  );

  always #5 CLK = ~CLK;

  // Expected {AN, SEG} after the k-th edge since reset release.
  function automatic logic [11:0] model_out();
    int         m, d;
    logic [3:0] nib, an;
    logic       dp;
    if (k == 0) return 12'hFFF;
    m = (k - 1) % P;
    if (m >= RD) return 12'hFFF;
    d   = ((k - 1) / P) % 4;
    nib = 4'((m_val >> (16 * int'(m_half) + 4 * d)) & 32'hF);
    case (d)
      0:       dp = ~m_zf;
      1:       dp = ~m_of;
      2:       dp = 1'b1;
      default: dp = ~m_half;
    endcase
    an = 4'hF ^ 4'(1 << d);
    return {an, dp, hex_tab[nib]};
  endfunction

  function automatic bit at_start(int d);
    return (k >= 1) && ((k - 1) % P == 0) && (((k - 1) / P) % 4 == d);
  endfunction

  task automatic check(string name, logic [11:0] act, logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got AN=%h SEG=%h, required AN=%h SEG=%h",
               name, act[11:8], act[7:0], exp[11:8], exp[7:0]);
    end
  endtask

  task automatic model_reset();
    k = 0;
    m_val = '0; m_zf = 1'b0; m_of = 1'b0; m_half = 1'b0;
  endtask

  // One clock edge: advance the model, then compare the DUT against it.
  task automatic step();
    logic [11:0] e;
    @(posedge CLK);
    if (!RST) begin
      model_reset();
      e = 12'hFFF;
    end else begin
      k++;
      e = model_out();
      if (!hold) begin
        m_val = value; m_zf = zf; m_of = of; m_half = half;
      end
    end
    #1;
    check($sformatf("model k=%0d", k), {AN, SEG}, e);
  endtask

  task automatic run_until_show(int d, string name);
    for (int i = 0; i < 8 * P && !at_start(d); i++) step();
    if (!at_start(d)) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: start of digit %0d not reached, got k=%0d", name, d, k);
    end
  endtask

  // Release reset between edges, then check the fixed opening sequence.
  task automatic release_and_check(string name);
    logic [3:0] exp_an [7];
    exp_an = '{4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hD};
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check($sformatf("%s edge 0", name), {AN, SEG}, 12'hFFF);
    for (int i = 1; i < 7; i++) begin
      step();
      n_checks++;
      if (AN !== exp_an[i]) begin
        n_fail++;
        $display("FAIL %s edge %0d: got AN=%h, required AN=%h", name, i, AN, exp_an[i]);
      end
    end
    $display("%s: opening sequence done at k=%0d", name, k);
  endtask

  initial begin
    vecs[0]  = '{32'h12345678, 1'b0, 1'b0, 1'b0, 0, 4'hE, 8'h80};
    vecs[1]  = '{32'h12345678, 1'b0, 1'b0, 1'b0, 1, 4'hD, 8'hF8};
    vecs[2]  = '{32'h12345678, 1'b0, 1'b0, 1'b0, 2, 4'hB, 8'h82};
    vecs[3]  = '{32'h12345678, 1'b0, 1'b0, 1'b0, 3, 4'h7, 8'h92};
    vecs[4]  = '{32'h12345678, 1'b0, 1'b0, 1'b1, 0, 4'hE, 8'h99};
    vecs[5]  = '{32'h12345678, 1'b0, 1'b0, 1'b1, 1, 4'hD, 8'hB0};
    vecs[6]  = '{32'h12345678, 1'b0, 1'b0, 1'b1, 2, 4'hB, 8'hA4};
    vecs[7]  = '{32'h12345678, 1'b0, 1'b0, 1'b1, 3, 4'h7, 8'h79};
    vecs[8]  = '{32'h00000000, 1'b1, 1'b1, 1'b0, 0, 4'hE, 8'h40};
    vecs[9]  = '{32'h00000000, 1'b1, 1'b1, 1'b0, 1, 4'hD, 8'h40};
    vecs[10] = '{32'h00000000, 1'b1, 1'b1, 1'b0, 2, 4'hB, 8'hC0};
    vecs[11] = '{32'h00000000, 1'b1, 1'b1, 1'b0, 3, 4'h7, 8'hC0};

    // Scenario 1: reset held for 5 cycles, then the opening sequence.
    #2 RST = 1'b0;
    model_reset();
    #1 check("reset async", {AN, SEG}, 12'hFFF);
    for (int i = 0; i < 5; i++) step();
    release_and_check("reset release");

    // Scenarios 2, 3, 5: table-driven digit patterns.
    for (int i = 0; i < 12; i++) begin
      value = vecs[i].value; zf = vecs[i].zf; of = vecs[i].of;
      half = vecs[i].half; hold = 1'b0;
      step();
      step();
      run_until_show(vecs[i].digit, $sformatf("vec %0d", i));
      check($sformatf("vec %0d", i), {AN, SEG}, {vecs[i].an, vecs[i].seg});
      $display("vec %0d: value=%h half=%0d digit=%0d AN=%h SEG=%h",
               i, vecs[i].value, vecs[i].half, vecs[i].digit, AN, SEG);
    end

    // Scenario 4: hold freezes ABCD while the input moves to FFFFFFFF.
    begin
      logic [7:0] held_seg [4];
      held_seg = '{8'hA1, 8'hC6, 8'h83, 8'h88};
      value = 32'h0000ABCD; zf = 1'b0; of = 1'b0; half = 1'b0; hold = 1'b0;
      step();
      step();
      hold  = 1'b1;
      value = 32'hFFFFFFFF;
      step();
      for (int d = 0; d < 4; d++) begin
        run_until_show(d, "hold");
        check($sformatf("hold digit %0d", d), {AN, SEG}, {4'hF ^ 4'(1 << d), held_seg[d]});
        $display("hold digit %0d: AN=%h SEG=%h", d, AN, SEG);
      end
      hold = 1'b0;
      step();
      step();
      for (int d = 0; d < 4; d++) begin
        run_until_show(d, "unhold");
        check($sformatf("unhold digit %0d", d), {AN, SEG}, {4'hF ^ 4'(1 << d), 8'h8E});
        $display("unhold digit %0d: AN=%h SEG=%h", d, AN, SEG);
      end
    end

    // Randomized traffic against the model, hold and half toggling freely.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) value = $urandom;
      zf   = 1'($urandom_range(0, 1));
      of   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) half = ~half;
      hold = ($urandom_range(0, 9) < 3);
      step();
    end
    $display("random: 400 cycles done, k=%0d", k);

    // Scenario 6: asynchronous reset in the middle of SHOW digit 2.
    value = 32'h12345678; hold = 1'b0; half = 1'b0;
    run_until_show(2, "async reset");
    step();
    #3;
    RST = 1'b0;
    model_reset();
    #1;
    check("async reset mid-show", {AN, SEG}, 12'hFFF);
    $display("async reset mid-show: AN=%h SEG=%h", AN, SEG);
    step();
    step();
    release_and_check("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
